// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit, 1 MB memory port between CPU (0), DMA (1) and video (2).
// Optional bus-lock support is compiled in with `define ARB_LOCK_EN.
module mem_bus_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned NPORT   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NPORT-1:0] req,
    input  logic [19:0]      addr0,
    input  logic [19:0]      addr1,
    input  logic [19:0]      addr2,
    input  logic [7:0]       wdata0,
    input  logic [7:0]       wdata1,
    input  logic [7:0]       wdata2,
    input  logic [NPORT-1:0] wr,
`ifdef ARB_LOCK_EN
    input  logic [NPORT-1:0] lock,
`endif
    output logic [NPORT-1:0] gnt,
    output logic [NPORT-1:0] ack,
    output logic [7:0]       rdata,
    output logic [19:0]      address,
    output logic [7:0]       out,
    output logic             we,
    input  logic [7:0]       in
);

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PTR_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [PTR_W-1:0]    last_q,    last_d;
    logic [NPORT-1:0]    gnt_q,     gnt_d;
    logic [NPORT-1:0]    ack_q,     ack_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   out_q,     out_d;
    logic                we_q,      we_d;
    logic                wr_q,      wr_d;
`ifdef ARB_LOCK_EN
    logic                locked_vld_q, locked_vld_d;
    logic [PTR_W-1:0]    locked_q,     locked_d;
`endif

    logic                win_vld_c;
    logic [PTR_W-1:0]    win_c;
    logic [ADDR_W-1:0]   win_addr_c;
    logic [DATA_W-1:0]   win_wdata_c;
    logic                win_wr_c;

    // Rotation order 0 -> 1 -> 2 -> 0; the unused code 3 maps back to 0.
    function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(2)) ? PTR_W'(0) : PTR_W'(p + PTR_W'(1));
    endfunction

    // Per-port bit select where a nonexistent port reads as "not set".
    function automatic logic bit_at(input logic [NPORT-1:0] v, input logic [PTR_W-1:0] p);
        logic r;
        case (p)
            PTR_W'(0): r = v[0];
            PTR_W'(1): r = v[1];
            PTR_W'(2): r = v[2];
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Winner selection: scan last+1, last+2, last+3; a held lock overrides rotation.
    always_comb begin
        logic [PTR_W-1:0] cand;
        win_vld_c = 1'b0;
        win_c     = '0;
        cand      = last_q;
        for (int i = 0; i < 3; i++) begin
            cand = next_port(cand);
            if (!win_vld_c && bit_at(req, cand)) begin
                win_vld_c = 1'b1;
                win_c     = cand;
            end
        end
`ifdef ARB_LOCK_EN
        if (locked_vld_q && bit_at(req, locked_q)) begin
            win_vld_c = 1'b1;
            win_c     = locked_q;
        end
`endif
    end

    // Request payload of the winning port.
    always_comb begin
        win_addr_c  = '0;
        win_wdata_c = '0;
        win_wr_c    = 1'b0;
        case (win_c)
            PTR_W'(0): begin
                win_addr_c  = addr0;
                win_wdata_c = wdata0;
                win_wr_c    = wr[0];
            end
            PTR_W'(1): begin
                win_addr_c  = addr1;
                win_wdata_c = wdata1;
                win_wr_c    = wr[1];
            end
            PTR_W'(2): begin
                win_addr_c  = addr2;
                win_wdata_c = wdata2;
                win_wr_c    = wr[2];
            end
            default: begin
                win_addr_c  = '0;
                win_wdata_c = '0;
                win_wr_c    = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        address_d = address_q;
        out_d     = out_q;
        we_d      = we_q;
        wr_d      = wr_q;
`ifdef ARB_LOCK_EN
        locked_vld_d = locked_vld_q;
        locked_d     = locked_q;
`endif

        case (state_q)
            S_IDLE: begin
                we_d  = 1'b0;
                ack_d = '0;
`ifdef ARB_LOCK_EN
                // A lock lives only until the IDLE that follows its ACK.
                locked_vld_d = 1'b0;
`endif
                if (win_vld_c) begin
                    address_d = win_addr_c;
                    out_d     = win_wdata_c;
                    we_d      = win_wr_c;
                    wr_d      = win_wr_c;
                    gnt_d     = NPORT'(1) << win_c;
                    last_d    = win_c;
                    cnt_d     = CNT_W'(LATENCY - 1);
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                we_d = 1'b0;
                if (cnt_q == '0) begin
                    if (!wr_q) begin
                        rdata_d = in;
                    end
                    ack_d   = gnt_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_ACK: begin
                ack_d   = '0;
                gnt_d   = '0;
                state_d = S_IDLE;
`ifdef ARB_LOCK_EN
                locked_vld_d = |(lock & gnt_q);
                locked_d     = last_q;
`endif
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ack_d   = '0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_q    <= PTR_W'(2);
            gnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            address_q <= '0;
            out_q     <= '0;
            we_q      <= 1'b0;
            wr_q      <= 1'b0;
`ifdef ARB_LOCK_EN
            locked_vld_q <= 1'b0;
            locked_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            address_q <= address_d;
            out_q     <= out_d;
            we_q      <= we_d;
            wr_q      <= wr_d;
`ifdef ARB_LOCK_EN
            locked_vld_q <= locked_vld_d;
            locked_q     <= locked_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign address = address_q;
    assign out     = out_q;
    assign we      = we_q;

endmodule
